// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// The optional same-cycle queue bypass is enabled by FETCH_QUEUE_BYPASS_EN.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order {pc, instr} circular buffer feeding decode.
// Head is read straight from the storage registers.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [31:0]        pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [31:0]        pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [2:0]         count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [31:0]        pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [2:0]         count_q, count_d;
    logic               do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != 3'd0) && !flush_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = 3'd0;
        end else begin
            if (do_push) tail_d = inc(tail_q);
            if (do_pop)  head_d = inc(head_q);
            count_d = count_q + 3'(do_push) - 3'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 3'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (do_push) begin
            pc_q[tail_q]    <= pc_i;
            instr_q[tail_q] <= instr_i;
        end
    end

    assign valid_o = (count_q != 3'd0);
    assign pc_o    = pc_q[head_q];
    assign instr_o = instr_q[head_q];
    assign count_o = count_q;

    // Slot reservation upstream must make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && count_q == 3'(DEPTH)));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, one outstanding memory read, queue to decode.
// Define FETCH_QUEUE_BYPASS_EN to present a response to decode in its arrival cycle.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        pc_out,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        redir_pc, rsp_pc, fifo_pc;
    logic [INSTR_W-1:0] fifo_instr;
    logic [2:0]         fifo_count;
    logic [3:0]         occ_next;
    logic               rsp_ok, byp, fifo_push, fifo_pop;
    logic               fifo_valid, slot_free;

    assign redir_pc = word_align(redirect_pc);
    // In WAIT the PC has already advanced past the issued word.
    assign rsp_pc   = fetch_pc_q - 32'd4;
    assign rsp_ok   = (state_q == WAIT) && mem_rvalid && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = rsp_ok && (fifo_count == 3'd0);
`else
    assign byp = 1'b0;
`endif

    assign fifo_push = rsp_ok && !(byp && instr_ready);
    assign fifo_pop  = fifo_valid && instr_ready;
    assign occ_next  = {1'b0, fifo_count} + {3'b0, fifo_push}
                     - {3'b0, fifo_pop};
    assign slot_free = occ_next < 4'(QUEUE_DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            IDLE: begin
                if (redirect) fetch_pc_d = redir_pc;
                else if (slot_free) state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                    if (mem_gnt) state_d = DROP;
                end else if (mem_gnt) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                    state_d    = mem_rvalid ? REQ : DROP;
                end else if (mem_rvalid) begin
                    state_d = slot_free ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect) fetch_pc_d = redir_pc;
                if (mem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            fetch_pc_q <= word_align(RESET_PC);
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push_i  (fifo_push),
        .pc_i    (rsp_pc),
        .instr_i (mem_rdata),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .valid_o (fifo_valid),
        .pc_o    (fifo_pc),
        .instr_o (fifo_instr),
        .count_o (fifo_count)
    );

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = fetch_pc_q;
    assign instr_valid = fifo_valid || byp;
    assign instr_out   = byp ? mem_rdata : fifo_instr;
    assign pc_out      = byp ? rsp_pc : fifo_pc;

endmodule
